// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared constants and state encoding for the SD data block receiver
package sd_pkg;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam int          CRC_LEN    = 16;

    localparam logic        BUS_1BIT   = 1'b0;
    localparam logic        BUS_4BIT   = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_START,
        S_DATA,
        S_CRC,
        S_END
    } rx_state_t;

endpackage

// File: rtl/sd_crc16.sv
// rtl/sd_crc16.sv - serial CRC16 (x^16+x^12+x^5+1, init 0), one bit per enabled clk
module sd_crc16
    import sd_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic feedback;

    assign feedback = bit_in ^ crc[15];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc <= '0;
        end else if (clear) begin
            crc <= '0;
        end else if (enable) begin
            crc <= {crc[14:0], 1'b0} ^ (feedback ? CRC16_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/sd_data_block_rx.sv
// rtl/sd_data_block_rx.sv - SD DAT-line block receiver with per-line CRC16 check and byte FIFO
module sd_data_block_rx
    import sd_pkg::*;
#(
    parameter int DATA_LINES      = 4,
    parameter int MAX_BLOCK_BYTES = 512,
    parameter int FIFO_DEPTH      = 16,
    parameter int TIMEOUT_W       = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sd_clk_rise,
    input  logic [DATA_LINES-1:0] dat_in,
    input  logic                  wide_bus,
    input  logic                  start,
    input  logic [9:0]            block_len,
    input  logic [TIMEOUT_W-1:0]  timeout,
    output logic                  busy,
    output logic                  done,
    output logic                  crc_err,
    output logic                  timeout_err,
    output logic                  overflow_err,
    output logic                  clk_stop_req,
    output logic [7:0]            byte_data,
    output logic                  byte_valid,
    input  logic                  byte_ready
);

    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [9:0]       MAX_LEN = 10'(MAX_BLOCK_BYTES);

    rx_state_t state, state_nxt;
    logic start_acc, done_set, timeout_set, crc_set;

    logic                 wide_q, wide_mode;
    logic [9:0]           len_q;
    logic [TIMEOUT_W-1:0] timeout_q, to_cnt, to_cnt_inc;
    logic                 to_hit;
    logic [2:0]           bit_cnt;
    logic [9:0]           byte_cnt;
    logic [3:0]           crc_cnt;
    logic [6:0]           shift_q;
    logic [7:0]           shift_nxt;
    logic                 byte_last;
    logic                 push_pend;
    logic [7:0]           push_data;

    logic [3:0]  dat4, line_used, line_bad;
    logic [15:0] crc_calc [4];
    logic [15:0] crc_rx   [4];
    logic        crc_en;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_cnt, fifo_cnt_nxt;
    logic             full, pop, push_ok, drop;

    // Absent lines read as idle-high so the rest of the logic is width independent.
    always_comb begin
        dat4                   = 4'hF;
        dat4[DATA_LINES-1:0]   = dat_in;
    end

    assign wide_mode  = (wide_q == BUS_4BIT);
    assign line_used  = wide_mode ? 4'hF : 4'h1;
    assign byte_last  = wide_mode ? bit_cnt[0] : (bit_cnt == 3'd7);
    assign shift_nxt  = wide_mode ? {shift_q[3:0], dat4} : {shift_q[6:0], dat4[0]};
    assign to_cnt_inc = to_cnt + 1'b1;
    assign to_hit     = (to_cnt_inc == timeout_q);
    assign crc_en     = (state == S_DATA) && sd_clk_rise;
    assign busy       = (state != S_IDLE);

    always_comb begin
        line_bad = '0;
        for (int i = 0; i < 4; i++) begin
            line_bad[i] = line_used[i] && ((crc_rx[i] != crc_calc[i]) || !dat4[i]);
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_line
        if (i < DATA_LINES) begin : g_crc
            sd_crc16 u_crc16 (
                .clk    (clk),
                .reset  (reset),
                .clear  (start_acc),
                .enable (crc_en && line_used[i]),
                .bit_in (dat4[i]),
                .crc    (crc_calc[i])
            );
        end else begin : g_none
            assign crc_calc[i] = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_acc   = 1'b0;
        done_set    = 1'b0;
        timeout_set = 1'b0;
        crc_set     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = S_WAIT_START;
                end
            end
            S_WAIT_START: begin
                if (sd_clk_rise) begin
                    if (!dat4[0]) begin
                        state_nxt = S_DATA;
                    end else if (to_hit) begin
                        timeout_set = 1'b1;
                        done_set    = 1'b1;
                        state_nxt   = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (sd_clk_rise && byte_last && (byte_cnt == len_q - 10'd1)) begin
                    state_nxt = S_CRC;
                end
            end
            S_CRC: begin
                if (sd_clk_rise && (crc_cnt == 4'(CRC_LEN - 1))) begin
                    state_nxt = S_END;
                end
            end
            S_END: begin
                if (sd_clk_rise) begin
                    crc_set   = |line_bad;
                    done_set  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wide_q    <= BUS_1BIT;
            len_q     <= '0;
            timeout_q <= '0;
            to_cnt    <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            crc_cnt   <= '0;
            shift_q   <= '0;
            push_pend <= 1'b0;
            push_data <= '0;
            for (int i = 0; i < 4; i++) begin
                crc_rx[i] <= '0;
            end
        end else begin
            push_pend <= 1'b0;
            if (start_acc) begin
                wide_q    <= (DATA_LINES == 4) ? wide_bus : BUS_1BIT;
                len_q     <= (block_len == 10'd0) ? MAX_LEN : block_len;
                timeout_q <= timeout;
                to_cnt    <= '0;
                bit_cnt   <= '0;
                byte_cnt  <= '0;
                crc_cnt   <= '0;
            end
            if (sd_clk_rise) begin
                case (state)
                    S_WAIT_START: to_cnt <= to_cnt_inc;
                    S_DATA: begin
                        shift_q <= shift_nxt[6:0];
                        if (byte_last) begin
                            bit_cnt   <= '0;
                            byte_cnt  <= byte_cnt + 10'd1;
                            push_pend <= 1'b1;
                            push_data <= shift_nxt;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    S_CRC: begin
                        crc_cnt <= crc_cnt + 4'd1;
                        for (int i = 0; i < 4; i++) begin
                            crc_rx[i] <= {crc_rx[i][14:0], dat4[i]};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // A push into a full FIFO still lands when the head is popped in the same clk.
    assign byte_valid   = (fifo_cnt != '0);
    assign byte_data    = byte_valid ? mem[rd_ptr] : 8'h00;
    assign full         = (fifo_cnt == DEPTH_C);
    assign pop          = byte_valid && byte_ready;
    assign push_ok      = push_pend && (!full || pop);
    assign drop         = push_pend && full && !pop;
    assign fifo_cnt_nxt = fifo_cnt + CNT_W'(push_ok) - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_cnt     <= '0;
            clk_stop_req <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_cnt     <= fifo_cnt_nxt;
            clk_stop_req <= (state_nxt == S_DATA) && ((DEPTH_C - fifo_cnt_nxt) < CNT_W'(2));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done         <= 1'b0;
            crc_err      <= 1'b0;
            timeout_err  <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            done <= done_set;
            if (start_acc) begin
                crc_err      <= 1'b0;
                timeout_err  <= 1'b0;
                overflow_err <= 1'b0;
            end else begin
                if (crc_set) begin
                    crc_err <= 1'b1;
                end
                if (timeout_set) begin
                    timeout_err <= 1'b1;
                end
                if (drop) begin
                    overflow_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_data_block_rx.sv
// tb/tb_sd_data_block_rx.sv - directed self-checking bench for sd_data_block_rx
module tb_sd_data_block_rx;

    localparam int TW          = 20;
    localparam int STALL_LIMIT = 3000;

    logic          clk = 1'b0;
    logic          reset, sd_clk_rise, wide_bus, start, byte_ready;
    logic [3:0]    dat_in;
    logic [9:0]    block_len;
    logic [TW-1:0] timeout;
    logic          busy, done, crc_err, timeout_err, overflow_err, clk_stop_req, byte_valid;
    logic [7:0]    byte_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    int   done_cnt    = 0;
    int   stop_cnt    = 0;
    int   done_strobe = 0;
    logic done_crc    = 1'b0;
    logic done_to     = 1'b0;
    logic done_busy   = 1'b0;

    int strobe_cnt  = 0;
    int bytes_sent  = 0;
    int stall_bytes = -1;
    int stall_rx    = -1;
    int max_stall   = 0;
    int base_rx     = 0;
    bit honor           = 1'b1;
    bit release_on_stop = 1'b0;

    always #5 clk = ~clk;

    sd_data_block_rx #(
        .DATA_LINES      (4),
        .MAX_BLOCK_BYTES (512),
        .FIFO_DEPTH      (16),
        .TIMEOUT_W       (TW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sd_clk_rise  (sd_clk_rise),
        .dat_in       (dat_in),
        .wide_bus     (wide_bus),
        .start        (start),
        .block_len    (block_len),
        .timeout      (timeout),
        .busy         (busy),
        .done         (done),
        .crc_err      (crc_err),
        .timeout_err  (timeout_err),
        .overflow_err (overflow_err),
        .clk_stop_req (clk_stop_req),
        .byte_data    (byte_data),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready)
    );

    always @(negedge clk) begin
        if (byte_valid && byte_ready) rx_q.push_back(byte_data);
        if (done) begin
            done_cnt    <= done_cnt + 1;
            done_crc    <= crc_err;
            done_to     <= timeout_err;
            done_busy   <= busy;
            done_strobe <= strobe_cnt;
        end
        if (clk_stop_req) stop_cnt <= stop_cnt + 1;
    end

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        crc_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Divider model: one strobe every 3 clk, held off while clk_stop_req is up.
    task automatic strobe(input logic [3:0] v);
        int w = 0;
        while (honor && clk_stop_req && w < STALL_LIMIT) begin
            if (release_on_stop && !byte_ready) begin
                stall_bytes = bytes_sent;
                stall_rx    = rx_q.size() - base_rx;
                byte_ready  = 1'b1;
            end
            tick();
            w++;
        end
        if (w > max_stall) max_stall = w;
        dat_in      = v;
        sd_clk_rise = 1'b1;
        strobe_cnt++;
        tick();
        sd_clk_rise = 1'b0;
        tick();
        tick();
    endtask

    task automatic arm(input int len, input bit wide, input int to);
        block_len = 10'(len);
        wide_bus  = wide;
        timeout   = TW'(to);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic fill_inc(input int n, input logic [7:0] first);
        tx_q.delete();
        for (int i = 0; i < n; i++) tx_q.push_back(8'(first + i));
    endtask

    task automatic send_block(input bit wide, input int bad_crc_line, input int bad_end_line,
                              input int abort_after);
        logic [15:0] crc [4];
        logic [3:0]  v;
        logic [7:0]  b;
        for (int l = 0; l < 4; l++) crc[l] = 16'h0000;
        bytes_sent = 0;
        strobe(4'hF);
        strobe(4'hF);
        strobe(wide ? 4'h0 : 4'hE);
        for (int k = 0; k < tx_q.size(); k++) begin
            if (k == abort_after) return;
            b = tx_q[k];
            if (wide) begin
                for (int h = 1; h >= 0; h--) begin
                    v = (h == 1) ? b[7:4] : b[3:0];
                    for (int l = 0; l < 4; l++) crc[l] = crc_step(crc[l], v[l]);
                    strobe(v);
                end
            end else begin
                for (int i = 7; i >= 0; i--) begin
                    v = {3'b111, b[i]};
                    crc[0] = crc_step(crc[0], v[0]);
                    strobe(v);
                end
            end
            bytes_sent++;
        end
        if (bad_crc_line >= 0) crc[bad_crc_line] = crc[bad_crc_line] ^ 16'h0100;
        for (int i = 15; i >= 0; i--) begin
            v = 4'hF;
            for (int l = 0; l < 4; l++) if (wide || l == 0) v[l] = crc[l][i];
            strobe(v);
        end
        v = 4'hF;
        if (bad_end_line >= 0) v[bad_end_line] = 1'b0;
        strobe(v);
        strobe(4'hF);
    endtask

    task automatic wait_rx(input int target, input int limit);
        for (int i = 0; i < limit && rx_q.size() < target; i++) tick();
    endtask

    task automatic check_bytes(input string tag, input int n);
        int bad = 0;
        chk({tag, "_byte_count"}, rx_q.size() - base_rx, n);
        for (int i = 0; i < n && base_rx + i < rx_q.size(); i++) begin
            if (rx_q[base_rx + i] !== tx_q[i]) bad++;
        end
        chk({tag, "_bad_bytes"}, bad, 0);
    endtask

    initial begin
        int d0;
        int s0;
        reset       = 1'b1;
        sd_clk_rise = 1'b0;
        wide_bus    = 1'b0;
        start       = 1'b0;
        byte_ready  = 1'b0;
        dat_in      = 4'hF;
        block_len   = '0;
        timeout     = '0;
        tick();
        tick();
        chk("reset_outputs", {busy, done, crc_err, timeout_err, overflow_err, clk_stop_req,
                              byte_valid, byte_data}, 0);
        reset = 1'b0;
        tick();

        // 1-bit mode, four bytes
        tx_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        base_rx = rx_q.size(); d0 = done_cnt; byte_ready = 1'b1;
        arm(4, 1'b0, 1000);
        chk("t1_busy_armed", busy, 1);
        send_block(1'b0, -1, -1, -1);
        wait_rx(base_rx + 4, 50);
        check_bytes("t1", 4);
        chk("t1_done", done_cnt - d0, 1);
        chk("t1_crc_err", done_crc, 0);
        chk("t1_busy_at_done", done_busy, 0);
        chk("t1_busy_after", busy, 0);

        // 4-bit mode, full 512-byte block
        fill_inc(512, 8'h00);
        base_rx = rx_q.size(); d0 = done_cnt; s0 = stop_cnt;
        arm(0, 1'b1, 1000);
        send_block(1'b1, -1, -1, -1);
        wait_rx(base_rx + 512, 50);
        check_bytes("t2", 512);
        chk("t2_done", done_cnt - d0, 1);
        chk("t2_crc_err", done_crc, 0);
        chk("t2_overflow_err", overflow_err, 0);
        chk("t2_clk_stop_seen", stop_cnt - s0, 0);

        // 4-bit mode, corrupted CRC on DAT2, then bad end bit on DAT1
        fill_inc(8, 8'h40);
        base_rx = rx_q.size(); d0 = done_cnt;
        arm(8, 1'b1, 1000);
        send_block(1'b1, 2, -1, -1);
        wait_rx(base_rx + 8, 50);
        check_bytes("t3a", 8);
        chk("t3a_done", done_cnt - d0, 1);
        chk("t3a_crc_err", done_crc, 1);
        base_rx = rx_q.size(); d0 = done_cnt;
        arm(8, 1'b1, 1000);
        chk("t3b_crc_err_cleared", crc_err, 0);
        send_block(1'b1, -1, 1, -1);
        wait_rx(base_rx + 8, 50);
        check_bytes("t3b", 8);
        chk("t3b_crc_err", done_crc, 1);
        chk("t3b_timeout_err", done_to, 0);

        // start-bit timeout
        base_rx = rx_q.size(); d0 = done_cnt; s0 = strobe_cnt;
        arm(0, 1'b0, 100);
        for (int i = 0; i < 105; i++) strobe(4'hF);
        chk("t4_done", done_cnt - d0, 1);
        chk("t4_done_strobe", done_strobe - s0, 100);
        chk("t4_timeout_err", done_to, 1);
        chk("t4_busy_at_done", done_busy, 0);
        chk("t4_no_bytes", rx_q.size() - base_rx, 0);

        // stalled consumer, divider honours clk_stop_req
        fill_inc(64, 8'h80);
        base_rx = rx_q.size(); d0 = done_cnt;
        byte_ready = 1'b0; honor = 1'b1; release_on_stop = 1'b1; max_stall = 0;
        arm(64, 1'b1, 1000);
        send_block(1'b1, -1, -1, -1);
        release_on_stop = 1'b0;
        wait_rx(base_rx + 64, 300);
        chk("t5a_bytes_at_stall", stall_bytes, 15);
        chk("t5a_drained_at_stall", stall_rx, 0);
        chk("t5a_stall_bounded", max_stall < STALL_LIMIT, 1);
        check_bytes("t5a", 64);
        chk("t5a_done", done_cnt - d0, 1);
        chk("t5a_crc_err", done_crc, 0);
        chk("t5a_overflow_err", overflow_err, 0);

        // stalled consumer, divider ignores clk_stop_req
        fill_inc(64, 8'hC0);
        base_rx = rx_q.size(); d0 = done_cnt;
        byte_ready = 1'b0; honor = 1'b0;
        arm(64, 1'b1, 1000);
        send_block(1'b1, -1, -1, -1);
        chk("t5b_done", done_cnt - d0, 1);
        chk("t5b_crc_err", done_crc, 0);
        chk("t5b_overflow_err", overflow_err, 1);
        byte_ready = 1'b1;
        wait_rx(base_rx + 16, 100);
        for (int i = 0; i < 10; i++) tick();
        check_bytes("t5b", 16);
        honor = 1'b1;

        // reset in the middle of a block, then a fresh block
        fill_inc(512, 8'h33);
        byte_ready = 1'b0; d0 = done_cnt;
        arm(0, 1'b1, 1000);
        send_block(1'b1, -1, -1, 10);
        tick();
        chk("t6_valid_before_reset", byte_valid, 1);
        chk("t6_busy_before_reset", busy, 1);
        reset = 1'b1;
        #1;
        chk("t6_reset_outputs", {busy, done, crc_err, timeout_err, overflow_err, clk_stop_req,
                                 byte_valid, byte_data}, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("t6_no_done", done_cnt - d0, 0);
        tx_q = '{8'h12, 8'h34, 8'h56, 8'h78};
        base_rx = rx_q.size(); d0 = done_cnt; byte_ready = 1'b1;
        arm(4, 1'b1, 1000);
        send_block(1'b1, -1, -1, -1);
        wait_rx(base_rx + 4, 50);
        check_bytes("t6", 4);
        chk("t6_done", done_cnt - d0, 1);
        chk("t6_crc_err", done_crc, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no completion, expected summary before time limit");
        $fatal(1, "watchdog");
    end

endmodule
